entry_alloc_freelist: RTL and testbench

- Parametrised successor to the single-grant priority selector.
- Owns a registered free bitmap for N reservation-station/ROB entries.
- Grants up to ALLOC_WIDTH entries per cycle, all-or-nothing, and accepts multi-entry release and flush.
- Sits between rename/dispatch and the reservation station entry array.

---
 rtl/entry_alloc_freelist.sv | 129 ++++++++++++
 tb/tb_entry_alloc_freelist.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/entry_alloc_freelist.sv
// Free-list allocator: registered free bitmap, up to ALLOC_WIDTH all-or-nothing grants per cycle.
// Define ALLOC_ROUND_ROBIN_EN to start the search at a rotating pointer instead of entry 0.
module entry_alloc_freelist #(
    parameter  int NUM_ENTRIES = 8,
    parameter  int ALLOC_WIDTH = 2,
    localparam int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [ALLOC_WIDTH-1:0]             alloc_req_i,
    output logic                               alloc_ready_o,
    output logic [ALLOC_WIDTH*NUM_ENTRIES-1:0] alloc_grant_o,
    output logic [ALLOC_WIDTH-1:0]             alloc_valid_o,
    input  logic [NUM_ENTRIES-1:0]             release_i,
    input  logic                               flush_i,
    output logic [CNT_W-1:0]                   free_count_o,
    output logic                               full_o
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [NUM_ENTRIES-1:0]                  r_free;
    logic [CNT_W-1:0]                        r_cnt;
    logic                                    r_full;
    logic [IDX_W-1:0]                        w_base;
    logic [NUM_ENTRIES-1:0]                  w_search, w_rem, w_granted, w_free_nxt;
    logic [ALLOC_WIDTH-1:0][NUM_ENTRIES-1:0] w_pick, w_grant;
    logic [CNT_W-1:0]                        w_req_cnt, w_rel_cnt, w_gnt_cnt, w_cnt_nxt;

    // Maps a search-order position back to an entry index (i + base mod N).
    function automatic logic [IDX_W-1:0] wrap(input int i, input logic [IDX_W-1:0] base);
        int s;
        s = i + int'(base);
        if (s >= NUM_ENTRIES) s = s - NUM_ENTRIES;
        return IDX_W'(s);
    endfunction

`ifdef ALLOC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
    assign w_base = r_ptr;
`else
    assign w_base = '0;
`endif

    always_comb begin
        w_search = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            w_search[i] = r_free[wrap(i, w_base)];
    end

    // Slot k takes the lowest free bit left after slots 0..k-1 have taken theirs.
    always_comb begin
        w_rem  = w_search;
        w_pick = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                if (w_rem[i] && (w_pick[k] == '0)) w_pick[k][i] = 1'b1;
            w_rem = w_rem & ~w_pick[k];
        end
    end

    always_comb begin
        w_req_cnt = '0;
        w_rel_cnt = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++)
            w_req_cnt = w_req_cnt + CNT_W'(alloc_req_i[k]);
        for (int i = 0; i < NUM_ENTRIES; i++)
            w_rel_cnt = w_rel_cnt + CNT_W'(release_i[i] & ~r_free[i]);
    end

    assign alloc_ready_o = (r_cnt >= w_req_cnt) && !flush_i;

    // Requests are counted, not positional: popcount slots are served from slot 0.
    always_comb begin
        alloc_valid_o = '0;
        w_grant       = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            alloc_valid_o[k] = alloc_ready_o && (CNT_W'(k) < w_req_cnt);
            for (int i = 0; i < NUM_ENTRIES; i++)
                if (alloc_valid_o[k] && w_pick[k][i]) w_grant[k][wrap(i, w_base)] = 1'b1;
        end
    end

    always_comb begin
        w_granted = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++)
            w_granted = w_granted | w_grant[k];
    end

    assign alloc_grant_o = w_grant;
    assign w_gnt_cnt     = alloc_ready_o ? w_req_cnt : '0;
    assign w_free_nxt    = (r_free & ~w_granted) | release_i;
    assign w_cnt_nxt     = r_cnt - w_gnt_cnt + w_rel_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_free <= '1;
            r_cnt  <= CNT_W'(NUM_ENTRIES);
            r_full <= 1'b0;
        end else if (flush_i) begin
            r_free <= '1;
            r_cnt  <= CNT_W'(NUM_ENTRIES);
            r_full <= 1'b0;
        end else begin
            r_free <= w_free_nxt;
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == '0);
        end
    end

`ifdef ALLOC_ROUND_ROBIN_EN
    // Pointer follows the last entry actually granted this cycle.
    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int k = 0; k < ALLOC_WIDTH; k++)
            for (int i = 0; i < NUM_ENTRIES; i++)
                if (alloc_valid_o[k] && w_pick[k][i]) w_ptr_nxt = wrap(i + 1, r_ptr);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      r_ptr <= '0;
        else if (flush_i) r_ptr <= '0;
        else              r_ptr <= w_ptr_nxt;
    end
`endif

    assign free_count_o = r_cnt;
    assign full_o       = r_full;

endmodule

// File: tb/tb_entry_alloc_freelist.sv
// Bench for entry_alloc_freelist: directed scenarios plus randomized traffic against a queue-based model.
module tb_entry_alloc_freelist;
    localparam int N  = 8;
    localparam int A  = 2;
    localparam int CW = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [A-1:0]    alloc_req_i = '0;
    logic            alloc_ready_o;
    logic [A*N-1:0]  alloc_grant_o;
    logic [A-1:0]    alloc_valid_o;
    logic [N-1:0]    release_i = '0;
    logic            flush_i = 1'b0;
    logic [CW-1:0]   free_count_o;
    logic            full_o;

    entry_alloc_freelist #(.NUM_ENTRIES(N), .ALLOC_WIDTH(A)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .alloc_req_i(alloc_req_i),
        .alloc_ready_o(alloc_ready_o), .alloc_grant_o(alloc_grant_o),
        .alloc_valid_o(alloc_valid_o), .release_i(release_i), .flush_i(flush_i),
        .free_count_o(free_count_o), .full_o(full_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: free bitmap and search start; count is derived from the bitmap.
    bit [N-1:0]   m_free = '1;
    int           m_ptr  = 0;
    bit           e_ready;
    bit [A-1:0]   e_valid;
    bit [A*N-1:0] e_grant;
    bit [N-1:0]   e_free_n;
    int           e_ptr_n;

    logic           o_ready, o_full;
    logic [A-1:0]   o_valid;
    logic [A*N-1:0] o_grant;
    logic [CW-1:0]  o_cnt;

    task automatic model_eval(input bit [A-1:0] req, input bit [N-1:0] rel, input bit fl);
        int order[$];
        int n;
        n = $countones(req);
        for (int s = 0; s < N; s++)
            if (m_free[(m_ptr + s) % N]) order.push_back((m_ptr + s) % N);
        e_ready  = !fl && (order.size() >= n);
        e_valid  = '0;
        e_grant  = '0;
        e_free_n = m_free;
        e_ptr_n  = m_ptr;
        if (fl) begin
            e_free_n = '1;
            e_ptr_n  = 0;
        end else begin
            if (e_ready)
                for (int k = 0; k < n; k++) begin
                    e_valid[k]               = 1'b1;
                    e_grant[k*N + order[k]]  = 1'b1;
                    e_free_n[order[k]]       = 1'b0;
`ifdef ALLOC_ROUND_ROBIN_EN
                    e_ptr_n = (order[k] + 1) % N;
`endif
                end
            e_free_n = e_free_n | rel;
        end
    endtask

    // Drives one cycle, captures combinational outputs before the edge and registered ones after.
    task automatic do_cycle(input bit [A-1:0] req, input bit [N-1:0] rel, input bit fl);
        @(negedge clk_i);
        alloc_req_i = req;
        release_i   = rel;
        flush_i     = fl;
        model_eval(req, rel, fl);
        #1;
        o_ready = alloc_ready_o;
        o_valid = alloc_valid_o;
        o_grant = alloc_grant_o;
        @(posedge clk_i);
        m_free = e_free_n;
        m_ptr  = e_ptr_n;
        #1;
        o_cnt  = free_count_o;
        o_full = full_o;
        alloc_req_i = '0;
        release_i   = '0;
        flush_i     = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        n_cmp++; if (free_count_o !== 4'd8) begin n_bad++; $display("FAIL reset_count got %0d want 8", free_count_o); end
        n_cmp++; if (full_o !== 1'b0) begin n_bad++; $display("FAIL reset_full got %0b want 0", full_o); end
        n_cmp++; if (alloc_ready_o !== 1'b1 || alloc_valid_o !== 2'b00) begin n_bad++; $display("FAIL reset_idle got ready=%0b valid=%b want 1/00", alloc_ready_o, alloc_valid_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_basic_alloc();
        do_cycle(2'b11, 8'h00, 1'b0);
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready got %0b want 1", o_ready); end
        n_cmp++; if (o_grant !== 16'h0201) begin n_bad++; $display("FAIL basic_grant got %h want 0201", o_grant); end
        n_cmp++; if (o_valid !== 2'b11) begin n_bad++; $display("FAIL basic_valid got %b want 11", o_valid); end
        n_cmp++; if (o_cnt !== 4'd6) begin n_bad++; $display("FAIL basic_count got %0d want 6", o_cnt); end
    endtask

    task automatic test_exhaust();
        do_cycle(2'b11, 8'h00, 1'b0);
        do_cycle(2'b11, 8'h00, 1'b0);
        do_cycle(2'b01, 8'h00, 1'b0);
        n_cmp++; if (o_cnt !== 4'd1) begin n_bad++; $display("FAIL exhaust_count1 got %0d want 1", o_cnt); end
        do_cycle(2'b11, 8'h00, 1'b0);
        n_cmp++; if (o_ready !== 1'b0 || o_valid !== 2'b00 || o_grant !== 16'h0) begin n_bad++; $display("FAIL exhaust_reject got ready=%0b valid=%b grant=%h want 0/00/0000", o_ready, o_valid, o_grant); end
        n_cmp++; if (o_cnt !== 4'd1) begin n_bad++; $display("FAIL exhaust_hold got %0d want 1", o_cnt); end
        do_cycle(2'b01, 8'h00, 1'b0);
        n_cmp++; if (o_grant !== 16'h0080 || o_valid !== 2'b01) begin n_bad++; $display("FAIL exhaust_last got grant=%h valid=%b want 0080/01", o_grant, o_valid); end
        n_cmp++; if (o_full !== 1'b1 || o_cnt !== 4'd0) begin n_bad++; $display("FAIL exhaust_full got full=%0b cnt=%0d want 1/0", o_full, o_cnt); end
    endtask

    task automatic test_release_same_cycle();
        do_cycle(2'b00, 8'h06, 1'b0);
        n_cmp++; if (o_cnt !== 4'd2 || o_full !== 1'b0) begin n_bad++; $display("FAIL rel_setup got cnt=%0d full=%0b want 2/0", o_cnt, o_full); end
        do_cycle(2'b01, 8'h01, 1'b0);
        n_cmp++; if (o_grant !== 16'h0002) begin n_bad++; $display("FAIL rel_same_grant got %h want 0002", o_grant); end
        n_cmp++; if (o_cnt !== 4'd2) begin n_bad++; $display("FAIL rel_same_count got %0d want 2", o_cnt); end
        // free is now 8'h05; grant entries 0 and 2 while the upper nibble comes back
        do_cycle(2'b11, 8'hF0, 1'b0);
        n_cmp++; if (o_cnt !== 4'd4 || m_free !== 8'hF0) begin n_bad++; $display("FAIL rel_f0 got cnt=%0d model=%h want 4/f0", o_cnt, m_free); end
        do_cycle(2'b00, 8'hFF, 1'b0);
        n_cmp++; if (o_cnt !== 4'd8) begin n_bad++; $display("FAIL rel_ignore got %0d want 8", o_cnt); end
    endtask

    task automatic test_flush();
        do_cycle(2'b11, 8'h00, 1'b0);
        n_cmp++; if (o_grant !== e_grant || o_cnt !== 4'd6) begin n_bad++; $display("FAIL flush_pre got grant=%h cnt=%0d want %h/6", o_grant, o_cnt, e_grant); end
        do_cycle(2'b11, 8'h03, 1'b1);
        n_cmp++; if (o_ready !== 1'b0 || o_valid !== 2'b00 || o_grant !== 16'h0) begin n_bad++; $display("FAIL flush_block got ready=%0b valid=%b grant=%h want 0/00/0000", o_ready, o_valid, o_grant); end
        n_cmp++; if (o_cnt !== 4'd8 || o_full !== 1'b0) begin n_bad++; $display("FAIL flush_count got cnt=%0d full=%0b want 8/0", o_cnt, o_full); end
        do_cycle(2'b11, 8'h00, 1'b0);
        n_cmp++; if (o_grant !== 16'h0201) begin n_bad++; $display("FAIL flush_after got %h want 0201", o_grant); end
    endtask

    task automatic test_random();
        bit [A-1:0]   req;
        bit [N-1:0]   rel;
        bit [N-1:0]   gmask;
        bit           fl;
        int           pick;
        for (int c = 0; c < 400; c++) begin
            pick = $urandom_range(0, 2);
            req  = (pick == 0) ? 2'b00 : (pick == 1) ? 2'b01 : 2'b11;
            fl   = ($urandom_range(0, 24) == 0);
            model_eval(req, '0, fl);
            gmask = e_grant[N-1:0] | e_grant[2*N-1:N];
            rel   = ($urandom_range(0, 2) == 0) ? (N'($urandom) & ~gmask) : '0;
            do_cycle(req, rel, fl);
            n_cmp++; if (o_ready !== e_ready || o_valid !== e_valid || o_grant !== e_grant) begin
                n_bad++; $display("FAIL rand_grant c=%0d got r=%0b v=%b g=%h want r=%0b v=%b g=%h", c, o_ready, o_valid, o_grant, e_ready, e_valid, e_grant);
            end
            n_cmp++; if (o_cnt !== CW'($countones(m_free)) || o_full !== (m_free == '0)) begin
                n_bad++; $display("FAIL rand_state c=%0d got cnt=%0d full=%0b want cnt=%0d full=%0b", c, o_cnt, o_full, $countones(m_free), (m_free == '0));
            end
        end
    endtask

`ifdef ALLOC_ROUND_ROBIN_EN
    task automatic test_round_robin();
        do_cycle(2'b00, 8'h00, 1'b1);
        do_cycle(2'b01, 8'h00, 1'b0);
        n_cmp++; if (o_grant !== 16'h0001) begin n_bad++; $display("FAIL rr_g0 got %h want 0001", o_grant); end
        do_cycle(2'b01, 8'h01, 1'b0);
        n_cmp++; if (o_grant !== 16'h0002) begin n_bad++; $display("FAIL rr_g1 got %h want 0002", o_grant); end
        do_cycle(2'b01, 8'h02, 1'b0);
        n_cmp++; if (o_grant !== 16'h0004) begin n_bad++; $display("FAIL rr_g2 got %h want 0004", o_grant); end
        do_cycle(2'b00, 8'h00, 1'b1);
        do_cycle(2'b11, 8'h00, 1'b0);
        do_cycle(2'b11, 8'h00, 1'b0);
        do_cycle(2'b11, 8'h00, 1'b0);
        do_cycle(2'b01, 8'h00, 1'b0);
        do_cycle(2'b00, 8'h01, 1'b0);
        do_cycle(2'b11, 8'h00, 1'b0);
        n_cmp++; if (o_grant !== 16'h0180 || o_valid !== 2'b11) begin n_bad++; $display("FAIL rr_wrap got grant=%h valid=%b want 0180/11", o_grant, o_valid); end
    endtask
`endif

    task automatic test_reset_mid();
        do_cycle(2'b00, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) do_cycle(2'b11, 8'h00, 1'b0);
        n_cmp++; if (o_full !== 1'b1) begin n_bad++; $display("FAIL mid_prefull got %0b want 1", o_full); end
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++; if (free_count_o !== 4'd8 || full_o !== 1'b0) begin n_bad++; $display("FAIL mid_reset got cnt=%0d full=%0b want 8/0", free_count_o, full_o); end
        m_free = '1;
        m_ptr  = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        do_cycle(2'b11, 8'h00, 1'b0);
        n_cmp++; if (o_grant !== 16'h0201 || o_cnt !== 4'd6) begin n_bad++; $display("FAIL mid_after got grant=%h cnt=%0d want 0201/6", o_grant, o_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before the bench completed");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_alloc();
        test_exhaust();
        test_release_same_cycle();
        test_flush();
        test_random();
`ifdef ALLOC_ROUND_ROBIN_EN
        test_round_robin();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
